// File: rtl/mips_lsu.sv
// mips_lsu: load/store unit feeding the MIPS data memory (one access per request).
// Optional LSU_STATS_EN adds saturating load/store/fault counters.
`ifndef MEM_READ8S
`define MEM_READ8S  4'h1
`define MEM_READ8U  4'h2
`define MEM_READ16S 4'h3
`define MEM_READ16U 4'h4
`define MEM_READ32  4'h5
`define MEM_WRITE8  4'h6
`define MEM_WRITE16 4'h7
`define MEM_WRITE32 4'h8
`endif

module mips_lsu #(
    parameter int          W       = 32,
    parameter int          L       = 6,
    parameter logic [3:0]  IDLE_OP = 4'h0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [31:0]   req_base,
    input  logic [15:0]   req_offset,
    input  logic [W-1:0]  req_wdata,
    input  logic [4:0]    req_rd,
    output logic [3:0]    mem_source,
    output logic [31:0]   addr,
    output logic [W-1:0]  data_in,
    input  logic [W-1:0]  data_out,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [W-1:0]  resp_data,
    output logic [4:0]    resp_rd,
    output logic          resp_we,
`ifdef LSU_STATS_EN
    output logic [31:0]   stat_loads,
    output logic [31:0]   stat_stores,
    output logic [31:0]   stat_faults,
`endif
    output logic [1:0]    resp_exc
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [32:0] MEM_BYTES = 33'd4 << L;

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] ea_nxt;
    logic [1:0]  fault_nxt;
    logic        accept;
    logic        op_rd, op_wr, op_h, op_w;
    logic        q_rd;

    assign req_ready  = (state == IDLE) | ((state == RESP) & resp_ready);
    assign accept     = req_valid & req_ready;
    assign ea_nxt     = req_base + {{16{req_offset[15]}}, req_offset};
    assign mem_source = (state == ACCESS) ? op_q : IDLE_OP;

    // classify the incoming op by direction and access size
    always_comb begin
        op_rd = 1'b0;
        op_wr = 1'b0;
        op_h  = 1'b0;
        op_w  = 1'b0;
        case (req_op)
            `MEM_READ8S,
            `MEM_READ8U:  op_rd = 1'b1;
            `MEM_READ16S,
            `MEM_READ16U: begin op_rd = 1'b1; op_h = 1'b1; end
            `MEM_READ32:  begin op_rd = 1'b1; op_w = 1'b1; end
            `MEM_WRITE8:  op_wr = 1'b1;
            `MEM_WRITE16: begin op_wr = 1'b1; op_h = 1'b1; end
            `MEM_WRITE32: begin op_wr = 1'b1; op_w = 1'b1; end
            default:      op_rd = 1'b0;
        endcase
    end

    // fault code of the request being accepted; illegal/out of range wins
    always_comb begin
        fault_nxt = 2'd0;
        if (!(op_rd | op_wr))
            fault_nxt = 2'd3;
        else if ({1'b0, ea_nxt} >= MEM_BYTES)
            fault_nxt = 2'd3;
        else if ((op_w & (ea_nxt[1:0] != 2'b00)) | (op_h & ea_nxt[0]))
            fault_nxt = op_rd ? 2'd1 : 2'd2;
    end

    // whether the in-flight op is a load
    always_comb begin
        q_rd = 1'b0;
        case (op_q)
            `MEM_READ8S, `MEM_READ8U, `MEM_READ16S,
            `MEM_READ16U, `MEM_READ32: q_rd = 1'b1;
            default:                   q_rd = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state: faults skip the memory cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESP: begin
                if (accept)
                    state_nxt = (fault_nxt != 2'd0) ? RESP : ACCESS;
                else if (state == RESP && resp_ready)
                    state_nxt = IDLE;
            end
            ACCESS:  state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // request capture, memory drive registers and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= IDLE_OP;
            rd_q       <= '0;
            addr       <= '0;
            data_in    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_we    <= 1'b0;
            resp_exc   <= 2'd0;
        end else begin
            if (accept) begin
                op_q <= req_op;
                rd_q <= req_rd;
                if (fault_nxt == 2'd0) begin
                    addr    <= ea_nxt;
                    data_in <= req_wdata;
                end
            end
            if (state == ACCESS) begin
                resp_valid <= 1'b1;
                resp_data  <= q_rd ? data_out : '0;
                resp_we    <= q_rd;
                resp_exc   <= 2'd0;
                resp_rd    <= rd_q;
            end else if (accept && fault_nxt != 2'd0) begin
                resp_valid <= 1'b1;
                resp_data  <= '0;
                resp_we    <= 1'b0;
                resp_exc   <= fault_nxt;
                resp_rd    <= req_rd;
            end else if (accept || (state == RESP && resp_ready)) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef LSU_STATS_EN
    logic hs;
    assign hs = resp_valid & resp_ready;

    // saturating per-kind counters, bumped on response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_faults <= '0;
        end else if (hs) begin
            if (resp_exc != 2'd0) begin
                if (stat_faults != 32'hFFFF_FFFF) stat_faults <= stat_faults + 1;
            end else if (resp_we) begin
                if (stat_loads != 32'hFFFF_FFFF) stat_loads <= stat_loads + 1;
            end else begin
                if (stat_stores != 32'hFFFF_FFFF) stat_stores <= stat_stores + 1;
            end
        end
    end
`endif

endmodule
